// File: rtl/pr_freeze_sequencer.sv
// pr_freeze_sequencer
//   Controller-side master for the per-region partial-reconfiguration freeze
//   handshake. It takes a PR request for one region, asks that region's
//   responder to stop, and opens freeze_ready to the bitstream engine. When
//   the engine reports completion, it asks the region to start again. Only
//   one region is sequenced at a time. Each ack phase has a timeout, and any
//   failure is recorded in a sticky error status.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   pr_begin       1-cycle pulse: start a sequence for pr_region (IDLE only)
//   pr_region      target region, sampled with pr_begin in IDLE
//   pr_done        1-cycle pulse: bitstream engine finished (FROZEN only)
//   err_clr        1-cycle pulse: clear sticky error status
//   stop_req       per-region stop request, active high, idle 0
//   stop_ack       per-region stop ack from the region responders
//   start_req      per-region start request, ACTIVE LOW, idle 1
//   start_ack      per-region start ack from the region responders
//   region_freeze  per-region isolation enable
//   freeze_ready   active region is frozen; bitstream may stream
//   seq_busy       high in every state except IDLE
//   seq_done       1-cycle pulse: sequence completed cleanly
//   seq_error      sticky error flag
//   seq_err_code   0 none, 1 stop timeout, 2 start timeout, 3 bad region

module pr_freeze_sequencer #(
    parameter int NUM_REGIONS    = 4,
    parameter int REGION_W       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pr_begin,
    input  logic [REGION_W-1:0]    pr_region,
    input  logic                   pr_done,
    input  logic                   err_clr,
    output logic [NUM_REGIONS-1:0] stop_req,
    input  logic [NUM_REGIONS-1:0] stop_ack,
    output logic [NUM_REGIONS-1:0] start_req,
    input  logic [NUM_REGIONS-1:0] start_ack,
    output logic [NUM_REGIONS-1:0] region_freeze,
    output logic                   freeze_ready,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic                   seq_error,
    output logic [1:0]             seq_err_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REGIONS-1:0] ONE_HOT0 = NUM_REGIONS'(1);
    localparam int unsigned NUM_REGIONS_U = NUM_REGIONS;

    localparam logic [1:0] CODE_STOP_TO  = 2'd1;
    localparam logic [1:0] CODE_START_TO = 2'd2;
    localparam logic [1:0] CODE_BAD_RGN  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STOP,
        S_FROZEN,
        S_START,
        S_ERROR
    } state_t;

    state_t                 state, state_d;
    logic [REGION_W-1:0]    rid, rid_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [NUM_REGIONS-1:0] stop_req_d, start_req_d, region_freeze_d;
    logic                   freeze_ready_d, seq_busy_d, seq_done_d;
    logic                   seq_error_d;
    logic [1:0]             seq_err_code_d;
    logic                   err_set;
    logic [1:0]             err_code_new;

    logic [NUM_REGIONS-1:0] rid_mask, begin_mask;
    logic                   stop_hit, start_hit;
    logic                   begin_bad;

    // One-hot masks for the latched region and the requested region; all
    // request-line updates go through these so only one index ever moves.
    always_comb begin
        rid_mask   = ONE_HOT0 << rid;
        begin_mask = ONE_HOT0 << pr_region;
        stop_hit   = |(stop_ack & rid_mask);
        start_hit  = |(start_ack & rid_mask);
        begin_bad  = 32'(pr_region) >= NUM_REGIONS_U;
    end

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the value each output register takes at the next edge.
    always_comb begin
        state_d         = state;
        rid_d           = rid;
        cnt_d           = cnt;
        stop_req_d      = stop_req;
        start_req_d     = start_req;
        region_freeze_d = region_freeze;
        freeze_ready_d  = freeze_ready;
        seq_done_d      = 1'b0;
        err_set         = 1'b0;
        err_code_new    = 2'd0;

        case (state)
            S_IDLE: begin
                if (pr_begin) begin
                    rid_d = pr_region;
                    if (begin_bad) begin
                        state_d      = S_ERROR;
                        err_set      = 1'b1;
                        err_code_new = CODE_BAD_RGN;
                    end else begin
                        state_d    = S_STOP;
                        stop_req_d = stop_req | begin_mask;
                        cnt_d      = '0;
                    end
                end
            end

            // An ack sampled on the last counted cycle still wins over the timeout.
            S_STOP: begin
                if (stop_hit) begin
                    state_d         = S_FROZEN;
                    region_freeze_d = region_freeze | rid_mask;
                    freeze_ready_d  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_d      = S_ERROR;
                    stop_req_d   = stop_req & ~rid_mask;
                    err_set      = 1'b1;
                    err_code_new = CODE_STOP_TO;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            S_FROZEN: begin
                if (pr_done) begin
                    state_d        = S_START;
                    stop_req_d     = stop_req & ~rid_mask;
                    start_req_d    = start_req & ~rid_mask;
                    freeze_ready_d = 1'b0;
                    cnt_d          = '0;
                end
            end

            // cnt==0 marks the entry cycle, where a stale start_ack must not count.
            // A start timeout leaves the region frozen on purpose.
            S_START: begin
                if ((cnt != '0) && start_hit) begin
                    state_d         = S_IDLE;
                    start_req_d     = start_req | rid_mask;
                    region_freeze_d = region_freeze & ~rid_mask;
                    seq_done_d      = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_d      = S_ERROR;
                    start_req_d  = start_req | rid_mask;
                    err_set      = 1'b1;
                    err_code_new = CODE_START_TO;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            S_ERROR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new error beats a simultaneous clear and overwrites any older code.
        if (err_set) begin
            seq_error_d    = 1'b1;
            seq_err_code_d = err_code_new;
        end else if (err_clr) begin
            seq_error_d    = 1'b0;
            seq_err_code_d = 2'd0;
        end else begin
            seq_error_d    = seq_error;
            seq_err_code_d = seq_err_code;
        end

        seq_busy_d = (state_d != S_IDLE);
    end

    // State and output registers. Reset drops every request and freeze line
    // at once, which also unfreezes a region caught mid-sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rid           <= '0;
            cnt           <= '0;
            stop_req      <= '0;
            start_req     <= '1;
            region_freeze <= '0;
            freeze_ready  <= 1'b0;
            seq_busy      <= 1'b0;
            seq_done      <= 1'b0;
            seq_error     <= 1'b0;
            seq_err_code  <= 2'd0;
        end else begin
            state         <= state_d;
            rid           <= rid_d;
            cnt           <= cnt_d;
            stop_req      <= stop_req_d;
            start_req     <= start_req_d;
            region_freeze <= region_freeze_d;
            freeze_ready  <= freeze_ready_d;
            seq_busy      <= seq_busy_d;
            seq_done      <= seq_done_d;
            seq_error     <= seq_error_d;
            seq_err_code  <= seq_err_code_d;
        end
    end

endmodule

// File: tb/tb_pr_freeze_sequencer.sv
// tb_pr_freeze_sequencer
//   Bench for pr_freeze_sequencer. The main instance has four regions and a
//   16-cycle timeout. A second instance with three regions covers the
//   bad-region path. The bench drives the responders itself. It tracks the
//   expected freeze map and the expected error status from the sequence
//   outcomes of each run.

module tb_pr_freeze_sequencer;

    localparam int TO = 16;

    logic       clk;
    logic       rst_n;
    logic       pr_begin;
    logic [1:0] pr_region;
    logic       pr_done;
    logic       err_clr;
    logic [3:0] stop_req, stop_ack, start_req, start_ack, region_freeze;
    logic       freeze_ready, seq_busy, seq_done, seq_error;
    logic [1:0] seq_err_code;

    logic       b_pr_begin;
    logic [1:0] b_pr_region;
    logic       b_pr_done;
    logic       b_err_clr;
    logic [2:0] b_stop_req, b_stop_ack, b_start_req, b_start_ack, b_region_freeze;
    logic       b_freeze_ready, b_seq_busy, b_seq_done, b_seq_error;
    logic [1:0] b_seq_err_code;

    logic [3:0] expFreeze;
    logic       expErr;
    logic [1:0] expCode;
    int         nChecks;
    int         nFail;

    pr_freeze_sequencer #(.NUM_REGIONS(4), .REGION_W(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .pr_begin(pr_begin), .pr_region(pr_region),
        .pr_done(pr_done), .err_clr(err_clr), .stop_req(stop_req), .stop_ack(stop_ack),
        .start_req(start_req), .start_ack(start_ack), .region_freeze(region_freeze),
        .freeze_ready(freeze_ready), .seq_busy(seq_busy), .seq_done(seq_done),
        .seq_error(seq_error), .seq_err_code(seq_err_code)
    );

    pr_freeze_sequencer #(.NUM_REGIONS(3), .REGION_W(2), .TIMEOUT_CYCLES(TO)) dut3 (
        .clk(clk), .rst_n(rst_n), .pr_begin(b_pr_begin), .pr_region(b_pr_region),
        .pr_done(b_pr_done), .err_clr(b_err_clr), .stop_req(b_stop_req), .stop_ack(b_stop_ack),
        .start_req(b_start_req), .start_ack(b_start_ack), .region_freeze(b_region_freeze),
        .freeze_ready(b_freeze_ready), .seq_busy(b_seq_busy), .seq_done(b_seq_done),
        .seq_error(b_seq_error), .seq_err_code(b_seq_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of pulses, advance past the next rising edge, then drop the pulses
    task automatic applyStimulus(input logic b, input logic [1:0] r, input logic d, input logic c);
        pr_begin  = b;
        pr_region = r;
        pr_done   = d;
        err_clr   = c;
        @(posedge clk);
        #1;
        pr_begin = 1'b0;
        pr_done  = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full sequence on the main instance.
    //   mode 0 = clean, mode 1 = stop ack withheld, mode 2 = start ack withheld.
    //   d/e are the responder delays, doneDly is the gap from freeze_ready to pr_done.
    task automatic runSeq(input int rid, input int mode, input int d, input int e,
                          input int doneDly, input bit noise, input bit clrBefore,
                          input bit clrAtErr);
        logic [3:0] mask;
        logic [3:0] expStart;
        mask     = 4'b0001 << rid;
        expStart = ~mask;

        if (clrBefore) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
            expErr  = 1'b0;
            expCode = 2'd0;
        end
        checkOutput("idle_busy", seq_busy, 1'b0);
        checkOutput("idle_freeze", region_freeze, expFreeze);
        checkOutput("idle_error", seq_error, expErr);
        checkOutput("idle_code", seq_err_code, expCode);

        if (noise) begin
            applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
            checkOutput("idle_prdone_ignored", seq_busy, 1'b0);
        end

        applyStimulus(1'b1, 2'(rid), 1'b0, 1'b0);
        checkOutput("begin_stop_req", stop_req, mask);
        checkOutput("begin_start_req", start_req, 4'hF);
        checkOutput("begin_busy", seq_busy, 1'b1);

        if (mode == 1) begin
            for (int i = 0; i < TO - 1; i++)
                applyStimulus(noise && i == 0, 2'($urandom), noise && i == 0, 1'b0);
            checkOutput("stopto_hold_req", stop_req, mask);
            checkOutput("stopto_no_ready", freeze_ready, 1'b0);
            applyStimulus(1'b0, 2'd0, 1'b0, clrAtErr);
            expErr  = 1'b1;
            expCode = 2'd1;
            checkOutput("stopto_stop_req", stop_req, 4'h0);
            checkOutput("stopto_error", seq_error, expErr);
            checkOutput("stopto_code", seq_err_code, expCode);
            checkOutput("stopto_freeze", region_freeze, expFreeze);
            checkOutput("stopto_busy", seq_busy, 1'b1);
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
            checkOutput("stopto_idle", seq_busy, 1'b0);
            return;
        end

        for (int i = 0; i < d; i++)
            applyStimulus(noise && i == 0, 2'($urandom), noise && i == 0, 1'b0);
        checkOutput("stop_wait_ready", freeze_ready, 1'b0);
        checkOutput("stop_wait_req", stop_req, mask);

        stop_ack = mask;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        expFreeze = expFreeze | mask;
        checkOutput("frozen_ready", freeze_ready, 1'b1);
        checkOutput("frozen_freeze", region_freeze, expFreeze);

        for (int i = 0; i < doneDly; i++)
            applyStimulus(noise && i == 0, 2'($urandom), 1'b0, 1'b0);
        checkOutput("frozen_hold_ready", freeze_ready, 1'b1);
        checkOutput("frozen_hold_req", stop_req, mask);
        checkOutput("frozen_hold_start", start_req, 4'hF);

        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        stop_ack = 4'h0;
        checkOutput("start_ready_off", freeze_ready, 1'b0);
        checkOutput("start_stop_req", stop_req, 4'h0);
        checkOutput("start_start_req", start_req, expStart);

        if (mode == 2) begin
            for (int i = 0; i < TO - 1; i++)
                applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
            checkOutput("startto_hold_req", start_req, expStart);
            applyStimulus(1'b0, 2'd0, 1'b0, clrAtErr);
            expErr  = 1'b1;
            expCode = 2'd2;
            checkOutput("startto_start_req", start_req, 4'hF);
            checkOutput("startto_freeze", region_freeze, expFreeze);
            checkOutput("startto_error", seq_error, expErr);
            checkOutput("startto_code", seq_err_code, expCode);
            checkOutput("startto_no_done", seq_done, 1'b0);
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
            checkOutput("startto_idle", seq_busy, 1'b0);
            return;
        end

        for (int i = 0; i < e; i++)
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        start_ack = mask;
        if (e == 0) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
            checkOutput("start_entry_ack_ignored", seq_done, 1'b0);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        start_ack = 4'h0;
        expFreeze = expFreeze & ~mask;
        checkOutput("done_pulse", seq_done, 1'b1);
        checkOutput("done_start_req", start_req, 4'hF);
        checkOutput("done_freeze", region_freeze, expFreeze);
        checkOutput("done_busy", seq_busy, 1'b0);
        checkOutput("done_error", seq_error, expErr);
        checkOutput("done_code", seq_err_code, expCode);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("done_pulse_end", seq_done, 1'b0);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nChecks     = 0;
        nFail       = 0;
        expFreeze   = 4'h0;
        expErr      = 1'b0;
        expCode     = 2'd0;
        rst_n       = 1'b0;
        pr_begin    = 1'b0;
        pr_region   = 2'd0;
        pr_done     = 1'b0;
        err_clr     = 1'b0;
        stop_ack    = 4'h0;
        start_ack   = 4'h0;
        b_pr_begin  = 1'b0;
        b_pr_region = 2'd0;
        b_pr_done   = 1'b0;
        b_err_clr   = 1'b0;
        b_stop_ack  = 3'h0;
        b_start_ack = 3'h0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_stop_req", stop_req, 4'h0);
        checkOutput("rst_start_req", start_req, 4'hF);
        checkOutput("rst_freeze", region_freeze, 4'h0);
        checkOutput("rst_ready", freeze_ready, 1'b0);
        checkOutput("rst_busy", seq_busy, 1'b0);
        checkOutput("rst_done", seq_done, 1'b0);
        checkOutput("rst_error", seq_error, 1'b0);
        checkOutput("rst_code", seq_err_code, 2'd0);
        checkOutput("rst3_start_req", b_start_req, 3'h7);
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

        $display("[TB] T1 clean sequence on region 2");
        runSeq(2, 0, 1, 1, 20, 1'b0, 1'b0, 1'b0);

        $display("[TB] T2 stop timeout on region 1, err_clr colliding with the error");
        runSeq(1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b1);

        $display("[TB] T3 start timeout on region 3, then clean recovery");
        runSeq(3, 2, 0, 0, 4, 1'b0, 1'b0, 1'b0);
        runSeq(3, 0, 2, 0, 3, 1'b0, 1'b0, 1'b0);

        $display("[TB] T4 bad region on three-region instance");
        b_pr_begin  = 1'b1;
        b_pr_region = 2'd3;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        b_pr_begin = 1'b0;
        checkOutput("bad_stop_req_1", b_stop_req, 3'h0);
        checkOutput("bad_start_req_1", b_start_req, 3'h7);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("bad_error", b_seq_error, 1'b1);
        checkOutput("bad_code", b_seq_err_code, 2'd3);
        checkOutput("bad_stop_req_2", b_stop_req, 3'h0);
        checkOutput("bad_start_req_2", b_start_req, 3'h7);
        checkOutput("bad_freeze", b_region_freeze, 3'h0);
        checkOutput("bad_idle", b_seq_busy, 1'b0);
        b_err_clr = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        b_err_clr = 1'b0;
        checkOutput("clr_error", b_seq_error, 1'b0);
        checkOutput("clr_code", b_seq_err_code, 2'd0);
        b_pr_begin  = 1'b1;
        b_err_clr   = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        b_pr_begin = 1'b0;
        b_err_clr  = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("bad_vs_clr_error", b_seq_error, 1'b1);
        checkOutput("bad_vs_clr_code", b_seq_err_code, 2'd3);
        b_pr_begin  = 1'b1;
        b_pr_region = 2'd2;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        b_pr_begin = 1'b0;
        checkOutput("r3_top_stop_req", b_stop_req, 3'b100);
        repeat (TO) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("r3_top_stopto_code", b_seq_err_code, 2'd1);
        checkOutput("r3_top_stopto_req", b_stop_req, 3'h0);

        $display("[TB] T5 ignored pr_begin/pr_done pulses");
        runSeq(1, 0, 2, 1, 5, 1'b1, 1'b1, 1'b0);

        $display("[TB] T6 reset while frozen on region 0");
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        stop_ack = 4'b0001;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("t6_frozen", freeze_ready, 1'b1);
        repeat (3) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_stop_req", stop_req, 4'h0);
        checkOutput("t6_start_req", start_req, 4'hF);
        checkOutput("t6_freeze", region_freeze, 4'h0);
        checkOutput("t6_ready", freeze_ready, 1'b0);
        checkOutput("t6_busy", seq_busy, 1'b0);
        stop_ack = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        expFreeze = 4'h0;
        expErr    = 1'b0;
        expCode   = 2'd0;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        runSeq(0, 0, 0, 0, 6, 1'b0, 1'b0, 1'b0);

        $display("[TB] Randomised sequences");
        for (int k = 0; k < 14; k++) begin
            int rsel, modeSel, m;
            rsel    = int'($urandom_range(0, 3));
            modeSel = int'($urandom_range(0, 9));
            m       = (modeSel < 6) ? 0 : ((modeSel < 8) ? 1 : 2);
            runSeq(rsel, m, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 20)), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
